// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: arbitration FSM states and response owner encoding.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef logic owner_t;

  localparam owner_t OWN_M0 = 1'b0;
  localparam owner_t OWN_M1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; prio selects the winner only when both request.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || !prio_i)) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous data memory: same-cycle grant and
// issue, one-cycle done/err response routed back to the issuing master.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,

  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic              m0_lock_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_done_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_rdata_o,

  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic              m1_lock_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_done_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_rdata_o,

  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i
);

  arb_state_e state_q;
  logic       prio_q;

  owner_t     rsp_owner_q;
  logic       rsp_read_q;
  logic       rsp_err_q;
  logic       rsp_valid_q;

  logic [1:0] req_eff;
  logic [1:0] gnt;
  logic       any_gnt;
  logic       sel_we;
  logic       misaligned;

  // Requests are masked by reset and by a lock held by the other master.
  always_comb begin
    req_eff = 2'b00;
    if (reset_ni) begin
      case (state_q)
        LOCK0:   req_eff = {1'b0, m0_req_i};
        LOCK1:   req_eff = {m1_req_i, 1'b0};
        default: req_eff = {m1_req_i, m0_req_i};
      endcase
    end
  end

  rr_arb2 u_rr_arb2 (
    .req_i  (req_eff),
    .prio_i (prio_q),
    .gnt_o  (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign any_gnt  = |gnt;

  // Idle cycles present master 0 address/data; mem_we keeps them harmless.
  always_comb begin
    mem_a_o    = gnt[1] ? m1_addr_i  : m0_addr_i;
    mem_wd_o   = gnt[1] ? m1_wdata_i : m0_wdata_i;
    sel_we     = gnt[1] ? m1_we_i    : m0_we_i;
    misaligned = (mem_a_o[1:0] != 2'b00);
    mem_we_o   = any_gnt && sel_we && !misaligned;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= ARB;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (req_eff == 2'b11) begin
            prio_q <= gnt[0];
          end
          if (gnt[0] && m0_lock_i) begin
            state_q <= LOCK0;
          end else if (gnt[1] && m1_lock_i) begin
            state_q <= LOCK1;
          end
        end
        LOCK0: if (!m0_lock_i) state_q <= ARB;
        LOCK1: if (!m1_lock_i) state_q <= ARB;
        default: state_q <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      rsp_owner_q <= OWN_M0;
      rsp_read_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_owner_q <= gnt[1] ? OWN_M1 : OWN_M0;
      rsp_read_q  <= !sel_we;
      rsp_err_q   <= misaligned;
      rsp_valid_q <= any_gnt;
    end
  end

  // Responses are suppressed while reset is held, discarding anything in flight.
  always_comb begin
    m0_done_o  = reset_ni && rsp_valid_q && (rsp_owner_q == OWN_M0);
    m1_done_o  = reset_ni && rsp_valid_q && (rsp_owner_q == OWN_M1);
    m0_err_o   = m0_done_o && rsp_err_q;
    m1_err_o   = m1_done_o && rsp_err_q;
    m0_rdata_o = (m0_done_o && rsp_read_q && !rsp_err_q) ? mem_rd_i : '0;
    m1_rdata_o = (m1_done_o && rsp_read_q && !rsp_err_q) ? mem_rd_i : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port synchronous memory.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;

  logic [DW-1:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[AW-1:2]] <= mem_wd;
    mem_rd <= mem[mem_a[AW-1:2]];
  end

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_lock_i  (m0_lock),
    .m0_addr_i  (m0_addr),
    .m0_wdata_i (m0_wdata),
    .m0_gnt_o   (m0_gnt),
    .m0_done_o  (m0_done),
    .m0_err_o   (m0_err),
    .m0_rdata_o (m0_rdata),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_lock_i  (m1_lock),
    .m1_addr_i  (m1_addr),
    .m1_wdata_i (m1_wdata),
    .m1_gnt_o   (m1_gnt),
    .m1_done_o  (m1_done),
    .m1_err_o   (m1_err),
    .m1_rdata_o (m1_rdata),
    .mem_we_o   (mem_we),
    .mem_a_o    (mem_a),
    .mem_wd_o   (mem_wd),
    .mem_rd_i   (mem_rd)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a cycle at the falling edge, apply inputs, then let combinational outputs settle.
  task automatic cyc(input logic rn,
                     input logic r0, input logic w0, input logic l0, input logic [AW-1:0] a0,
                     input logic [DW-1:0] d0,
                     input logic r1, input logic w1, input logic l1, input logic [AW-1:0] a1);
    @(negedge clk);
    reset_n = rn;
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = 32'h0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[2] = 32'h1111_2222;
    mem[3] = 32'h3333_4444;
    reset_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = '0; m1_wdata = '0;

    // 1: reset held with both requesting
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
      chk("rst_m0_gnt", m0_gnt, 0);
      chk("rst_m1_gnt", m1_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_m0_done", m0_done, 0);
      chk("rst_m1_done", m1_done, 0);
    end
    cyc(1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    chk("rel_m0_gnt", m0_gnt, 1);
    chk("rel_m1_gnt", m1_gnt, 0);

    // 2: write then read back
    cyc(1, 1, 1, 0, 8'h04, 32'hDEADBEEF, 0, 0, 0, 8'h00);
    chk("wr_gnt", m0_gnt, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_a", mem_a, 32'h04);
    chk("wr_mem_wd", mem_wd, 32'hDEADBEEF);
    chk("wr_m0_done_prev", m0_done, 1);
    chk("wr_m1_done_prev", m1_done, 0);
    cyc(1, 1, 0, 0, 8'h04, 0, 0, 0, 0, 8'h00);
    chk("rd_gnt", m0_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("wack_done", m0_done, 1);
    chk("wack_rdata", m0_rdata, 0);
    cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    chk("idle_gnt", m0_gnt, 0);
    chk("rd_done", m0_done, 1);
    chk("rd_err", m0_err, 0);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);

    // 3: contention alternates, starting from prio=0 after a reset pulse
    cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    chk("rp_done", m0_done, 0);
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("alt1_m0_gnt", m0_gnt, 1);
    chk("alt1_m1_gnt", m1_gnt, 0);
    chk("alt1_mem_a", mem_a, 32'h08);
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("alt2_m1_gnt", m1_gnt, 1);
    chk("alt2_m0_gnt", m0_gnt, 0);
    chk("alt2_mem_a", mem_a, 32'h0C);
    chk("alt2_m0_done", m0_done, 1);
    chk("alt2_m1_done", m1_done, 0);
    chk("alt2_m0_rdata", m0_rdata, 32'h1111_2222);
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("alt3_m0_gnt", m0_gnt, 1);
    chk("alt3_m1_done", m1_done, 1);
    chk("alt3_m0_done", m0_done, 0);
    chk("alt3_m1_rdata", m1_rdata, 32'h3333_4444);
    chk("alt3_m0_rdata", m0_rdata, 0);
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("alt4_m1_gnt", m1_gnt, 1);
    chk("alt4_m0_done", m0_done, 1);
    chk("alt4_m1_done", m1_done, 0);

    // 4: m1 locks for three grants against a persistent m0 request
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("pre_m0_gnt", m0_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 1, 8'h0C);
      chk("lock_m1_gnt", m1_gnt, 1);
      chk("lock_m0_gnt", m0_gnt, 0);
    end
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("unlock_m1_gnt", m1_gnt, 1);
    chk("unlock_m0_gnt", m0_gnt, 0);
    cyc(1, 1, 0, 0, 8'h08, 0, 1, 0, 0, 8'h0C);
    chk("after_m0_gnt", m0_gnt, 1);
    chk("after_m1_gnt", m1_gnt, 0);

    // 5: misaligned write is consumed but not performed
    cyc(1, 1, 1, 0, 8'h06, 32'hCAFEF00D, 0, 0, 0, 8'h00);
    chk("mis_gnt", m0_gnt, 1);
    chk("mis_mem_we", mem_we, 0);
    cyc(1, 1, 0, 0, 8'h04, 0, 0, 0, 0, 8'h00);
    chk("mis_done", m0_done, 1);
    chk("mis_err", m0_err, 1);
    chk("mis_rdata", m0_rdata, 0);
    cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    chk("mis_rb_err", m0_err, 0);
    chk("mis_rb_rdata", m0_rdata, 32'hDEADBEEF);

    // 6: reset discards an in-flight response and releases a lock
    cyc(1, 1, 0, 0, 8'h04, 0, 0, 0, 0, 8'h00);
    chk("fl_gnt", m0_gnt, 1);
    cyc(0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    chk("fl_rst_done", m0_done, 0);
    chk("fl_rst_rdata", m0_rdata, 0);
    cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    chk("fl_post_done", m0_done, 0);
    cyc(1, 0, 0, 0, 8'h00, 0, 1, 0, 1, 8'h0C);
    chk("lk_m1_gnt", m1_gnt, 1);
    cyc(0, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'h0C);
    chk("lk_rst_m1_gnt", m1_gnt, 0);
    chk("lk_rst_m1_done", m1_done, 0);
    cyc(1, 1, 0, 0, 8'h00, 0, 1, 0, 1, 8'h0C);
    chk("lk_post_m0_gnt", m0_gnt, 1);
    chk("lk_post_m1_gnt", m1_gnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
